// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared RAM/IO bus. Each access is sequenced around the RAM's
// one-cycle synchronous read: IDLE -> ACCESS (-> RDATA for reads) -> IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        grant,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  function automatic logic cmd_valid(input logic [1:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

  state_t      state_q;
  logic        owner_q;       // 0 = m0, 1 = m1
  logic        last_owner_q;
  logic [1:0]  cmd_q;
  logic [1:0]  grant_q;
  logic        m0_ack_q;
  logic        m1_ack_q;

  logic              req0_s;
  logic              req1_s;
  logic              pick1_s;
  logic [1:0]        win_cmd_s;
  logic [ADDR_W-1:0] own_addr_s;
  logic [DATA_W-1:0] own_wdata_s;

  // Winner selection: a tie goes to the master that did not own the bus last (RR) or to m0
  always_comb begin
    req0_s  = cmd_valid(m0_cmd);
    req1_s  = cmd_valid(m1_cmd);
    pick1_s = 1'b0;
    if (req1_s && !req0_s) begin
      pick1_s = 1'b1;
    end else if (req1_s && req0_s && (RR != 0) && !last_owner_q) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    win_cmd_s = pick1_s ? m1_cmd : m0_cmd;
  end

  // Access sequencer with registered grant and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cmd_q        <= CMD_NONE;
      grant_q      <= 2'b00;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_s || req1_s) begin
            state_q      <= S_ACCESS;
            owner_q      <= pick1_s;
            last_owner_q <= pick1_s;
            cmd_q        <= win_cmd_s;
            grant_q      <= pick1_s ? 2'b10 : 2'b01;
            m0_ack_q     <= !pick1_s && (win_cmd_s == CMD_WRITE);
            m1_ack_q     <= pick1_s && (win_cmd_s == CMD_WRITE);
          end else begin
            state_q  <= S_IDLE;
            grant_q  <= 2'b00;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (cmd_q == CMD_WRITE) begin
            state_q  <= S_IDLE;
            grant_q  <= 2'b00;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
          end else begin
            state_q  <= S_RDATA;
            m0_ack_q <= !owner_q;
            m1_ack_q <= owner_q;
          end
        end
        S_RDATA: begin
          state_q  <= S_IDLE;
          grant_q  <= 2'b00;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          grant_q  <= 2'b00;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Downstream bus follows the owner's live address/data; RDATA keeps READ asserted
  always_comb begin
    own_addr_s  = owner_q ? m1_addr : m0_addr;
    own_wdata_s = owner_q ? m1_wdata : m0_wdata;
    mem_cmd     = CMD_NONE;
    mem_addr    = {ADDR_W{1'b0}};
    mem_wdata   = {DATA_W{1'b0}};
    rdata       = {DATA_W{1'b0}};
    case (state_q)
      S_ACCESS: begin
        mem_cmd   = cmd_q;
        mem_addr  = own_addr_s;
        mem_wdata = own_wdata_s;
      end
      S_RDATA: begin
        mem_cmd   = CMD_READ;
        mem_addr  = own_addr_s;
        mem_wdata = own_wdata_s;
        rdata     = mem_rdata;
      end
      default: begin
        mem_cmd = CMD_NONE;
      end
    endcase
  end

  assign grant  = grant_q;
  assign m0_ack = m0_ack_q;
  assign m1_ack = m1_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small RAM/LED/SW bus model; a second RR=0 instance
// shares the master stimulus to check fixed priority.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m0_cmd, m1_cmd;
  logic [8:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        f_m0_ack, f_m1_ack;
  logic [15:0] f_rdata;
  logic [1:0]  f_grant, f_mem_cmd;
  logic [8:0]  f_mem_addr;
  logic [15:0] f_mem_wdata;

  logic [15:0] ram [0:255];
  logic [15:0] ram_dout;
  logic [7:0]  led;
  logic [7:0]  sw;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .RR(1)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .grant(grant), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .RR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(f_m0_ack),
    .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(f_m1_ack),
    .rdata(f_rdata), .grant(f_grant), .mem_cmd(f_mem_cmd), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(16'h0000)
  );

  // Downstream model: synchronous-read RAM, LED register at 9'h100, switches at 9'h140
  always @(posedge clk) begin
    if (mem_cmd == 2'b10) begin
      if (mem_addr == 9'h100) led <= mem_wdata[7:0];
      else if (!mem_addr[8]) ram[mem_addr[7:0]] <= mem_wdata;
    end
    ram_dout <= ram[mem_addr[7:0]];
  end
  assign mem_rdata = (mem_addr == 9'h140) ? {8'h00, sw} : ram_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd"}, 32'(mem_cmd), 32'h0);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
  endtask

  initial begin
    reset = 1'b1; sw = 8'h3C; led = 8'h00;
    m0_cmd = 2'b00; m0_addr = 9'h000; m0_wdata = 16'h0000;
    m1_cmd = 2'b00; m1_addr = 9'h000; m1_wdata = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    chk_idle("rst");
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);

    // 1: m0 write BEEF to 0x010
    m0_cmd = 2'b10; m0_addr = 9'h010; m0_wdata = 16'hBEEF;
    chk("t1_idle_cmd", 32'(mem_cmd), 32'h0);
    tick();
    chk("t1_cmd", 32'(mem_cmd), 32'h2);
    chk("t1_addr", 32'(mem_addr), 32'h010);
    chk("t1_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("t1_acks", 32'({m1_ack, m0_ack}), 32'h1);
    chk("t1_grant", 32'(grant), 32'h1);
    m0_cmd = 2'b00;
    tick();
    chk_idle("t1_done");
    chk("t1_ram", 32'(ram[8'h10]), 32'hBEEF);

    // 2: m1 read 0x010
    m1_cmd = 2'b01; m1_addr = 9'h010;
    tick();
    chk("t2_a_cmd", 32'(mem_cmd), 32'h1);
    chk("t2_a_grant", 32'(grant), 32'h2);
    chk("t2_a_acks", 32'({m1_ack, m0_ack}), 32'h0);
    chk("t2_a_rdata", 32'(rdata), 32'h0);
    tick();
    chk("t2_r_cmd", 32'(mem_cmd), 32'h1);
    chk("t2_r_addr", 32'(mem_addr), 32'h010);
    chk("t2_r_acks", 32'({m1_ack, m0_ack}), 32'h2);
    chk("t2_r_rdata", 32'(rdata), 32'hBEEF);
    m1_cmd = 2'b00;
    tick();
    chk_idle("t2_done");

    // 3: both read continuously after reset; RR alternates, fixed priority keeps m0
    reset = 1'b1; tick(); reset = 1'b0;
    m0_cmd = 2'b01; m0_addr = 9'h010; m1_cmd = 2'b01; m1_addr = 9'h010;
    tick();
    chk("t3_g1", 32'(grant), 32'h1);
    chk("t3_fp_g1", 32'(f_grant), 32'h1);
    tick();
    chk("t3_ack1", 32'({m1_ack, m0_ack}), 32'h1);
    chk("t3_rd1", 32'(rdata), 32'hBEEF);
    tick();
    chk("t3_gap", 32'(grant), 32'h0);
    tick();
    chk("t3_g2", 32'(grant), 32'h2);
    chk("t3_fp_g2", 32'(f_grant), 32'h1);
    tick();
    chk("t3_ack2", 32'({m1_ack, m0_ack}), 32'h2);
    chk("t3_fp_ack2", 32'({f_m1_ack, f_m0_ack}), 32'h1);
    tick();
    tick();
    chk("t3_g3", 32'(grant), 32'h1);
    chk("t3_fp_g3", 32'(f_grant), 32'h1);
    tick();
    m0_cmd = 2'b00; m1_cmd = 2'b00;
    tick();
    chk_idle("t3_done");

    // 4: m1 writes LED, m0 reads switches
    m1_cmd = 2'b10; m1_addr = 9'h100; m1_wdata = 16'h00A5;
    tick();
    chk("t4_wr_acks", 32'({m1_ack, m0_ack}), 32'h2);
    chk("t4_wr_addr", 32'(mem_addr), 32'h100);
    m1_cmd = 2'b00;
    tick();
    chk("t4_led", 32'(led), 32'hA5);
    m0_cmd = 2'b01; m0_addr = 9'h140;
    tick(); tick();
    chk("t4_sw_ack", 32'({m1_ack, m0_ack}), 32'h1);
    chk("t4_sw_rdata", 32'(rdata), 32'h003C);
    m0_cmd = 2'b00;
    tick();

    // 5: reset during RDATA of an m0 read, then a clean retry
    m0_cmd = 2'b01; m0_addr = 9'h010;
    tick(); tick();
    chk("t5_rdata_state", 32'(mem_cmd), 32'h1);
    reset = 1'b1;
    tick();
    chk_idle("t5_rst");
    chk("t5_rst_addr", 32'(mem_addr), 32'h0);
    chk("t5_rst_wdata", 32'(mem_wdata), 32'h0);
    reset = 1'b0;
    tick();
    chk("t5_re_grant", 32'(grant), 32'h1);
    tick();
    chk("t5_re_ack", 32'({m1_ack, m0_ack}), 32'h1);
    chk("t5_re_rdata", 32'(rdata), 32'hBEEF);
    m0_cmd = 2'b00;
    tick();

    // last owner was m0: reset must restore m1 as last owner so m0 wins the tie
    reset = 1'b1; tick(); reset = 1'b0;
    m0_cmd = 2'b01; m1_cmd = 2'b01;
    tick();
    chk("t5_tie_grant", 32'(grant), 32'h1);
    tick();
    m0_cmd = 2'b00; m1_cmd = 2'b00;
    tick();

    // 6: command 2'b11 is ignored
    m0_cmd = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("t6_ign");
    end
    m0_cmd = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
